cpu_control_unit: RTL and testbench

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

---
 rtl/cpu_control_unit.sv | 143 ++++++++++++++
 tb/tb_cpu_control_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Multi-cycle CPU control unit: Moore FSM producing the datapath control word
// and counting instructions that reach decode.
module cpu_control_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  opcode,
    input  logic [5:0]  func,
    input  logic        is_halted,
    output logic [15:0] signal,
    output logic [15:0] num_inst,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        StIf    = 4'd0,
        StId    = 4'd1,
        StExR   = 4'd2,
        StExI   = 4'd3,
        StExM   = 4'd4,
        StWbR   = 4'd5,
        StWbI   = 4'd6,
        StMemRd = 4'd7,
        StWbL   = 4'd8,
        StMemWr = 4'd9,
        StBrTgt = 4'd10,
        StBrCmp = 4'd11,
        StJmp   = 4'd12,
        StJal   = 4'd13,
        StJr    = 4'd14,
        StHalt  = 4'd15
    } state_e;

    localparam logic [5:0] FuncWwd  = 6'd28;
    localparam logic [5:0] FuncJpr  = 6'd25;
    localparam logic [5:0] FuncJrl  = 6'd26;
    localparam logic [5:0] FuncHlt  = 6'd29;
    localparam logic [3:0] OpAdi    = 4'd4;
    localparam logic [3:0] OpLwd    = 4'd7;

    state_e      state_q, state_d;
    logic        started_q;
    logic [3:0]  op_q;
    logic [5:0]  fn_q;
    logic [15:0] num_inst_q, num_inst_d;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode/func are captured when leaving ID so later states decode only from registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started_q  <= 1'b0;
            op_q       <= 4'd0;
            fn_q       <= 6'd0;
            num_inst_q <= 16'd0;
        end else begin
            started_q  <= 1'b1;
            num_inst_q <= num_inst_d;
            if (state_q == StId) begin
                op_q <= opcode;
                fn_q <= func;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (state_q == StHalt) begin
            state_d = StHalt;
        end else if (!started_q) begin
            state_d = StIf;
        end else if (is_halted) begin
            state_d = StHalt;
        end else begin
            case (state_q)
                StIf: state_d = StId;
                StId: begin
                    case (opcode)
                        4'd0, 4'd1, 4'd2, 4'd3: state_d = StBrTgt;
                        4'd4, 4'd5, 4'd6:       state_d = StExI;
                        4'd7, 4'd8:             state_d = StExM;
                        4'd9:                   state_d = StJmp;
                        4'd10:                  state_d = StJal;
                        4'd15: begin
                            if (func <= 6'd7 || func == FuncWwd) begin
                                state_d = StExR;
                            end else if (func == FuncJpr || func == FuncJrl) begin
                                state_d = StJr;
                            end else if (func == FuncHlt) begin
                                state_d = StHalt;
                            end else begin
                                state_d = StIf;
                            end
                        end
                        default:                state_d = StIf;
                    endcase
                end
                StExR:   state_d = (fn_q == FuncWwd) ? StIf : StWbR;
                StExI:   state_d = StWbI;
                StExM:   state_d = (op_q == OpLwd) ? StMemRd : StMemWr;
                StMemRd: state_d = StWbL;
                StBrTgt: state_d = StBrCmp;
                default: state_d = StIf;
            endcase
        end
    end

    assign num_inst_d = num_inst_q + {15'd0, (state_q == StIf) && (state_d == StId)};

    // Output decode; IF stays silent until the first clock after reset release.
    always_comb begin
        signal = 16'h0000;
        case (state_q)
            StIf:    signal = started_q ? 16'h0009 : 16'h0000;
            StId:    signal = 16'h0820;
            StExR:   signal = (fn_q == FuncWwd) ? 16'h2600 : 16'h2400;
            StExI:   signal = (op_q == OpAdi) ? 16'h3400 : 16'h3C00;
            StExM:   signal = 16'h1400;
            StWbR:   signal = 16'h0280;
            StWbI:   signal = 16'h0200;
            StMemRd: signal = 16'h0018;
            StWbL:   signal = 16'h0202;
            StMemWr: signal = 16'h0014;
            StBrTgt: signal = 16'h1000;
            StBrCmp: signal = 16'h4440;
            StJmp:   signal = 16'h8020;
            StJal:   signal = 16'h8320;
            StJr:    signal = (fn_q == FuncJrl) ? 16'h0720 : 16'h0420;
            default: signal = 16'h0000;
        endcase
    end

    assign num_inst = num_inst_q;
    assign state    = state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized bench for cpu_control_unit: each instruction's expected state walk and
// control words come from a per-instruction-class table, not from the FSM structure.
module tb_cpu_control_unit;

    logic        clk;
    logic        reset_n;
    logic [3:0]  opcode;
    logic [5:0]  func;
    logic        is_halted;
    logic [15:0] signal;
    logic [15:0] num_inst;
    logic [3:0]  state;

    int          total;
    int          bad;
    logic [15:0] num_m;

    typedef int q_t[$];

    cpu_control_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .opcode    (opcode),
        .func      (func),
        .is_halted (is_halted),
        .signal    (signal),
        .num_inst  (num_inst),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected sequence of states entered after IF, ending with the next IF (or HALT).
    function automatic q_t path_of(input logic [3:0] op, input logic [5:0] fn);
        q_t p;
        if (op <= 4'd3)                      p = '{1, 10, 11, 0};
        else if (op <= 4'd6)                 p = '{1, 3, 6, 0};
        else if (op == 4'd7)                 p = '{1, 4, 7, 8, 0};
        else if (op == 4'd8)                 p = '{1, 4, 9, 0};
        else if (op == 4'd9)                 p = '{1, 12, 0};
        else if (op == 4'd10)                p = '{1, 13, 0};
        else if (op == 4'd15 && fn <= 6'd7)  p = '{1, 2, 5, 0};
        else if (op == 4'd15 && fn == 6'd28) p = '{1, 2, 0};
        else if (op == 4'd15 && (fn == 6'd25 || fn == 6'd26)) p = '{1, 14, 0};
        else if (op == 4'd15 && fn == 6'd29) p = '{1, 15};
        else                                 p = '{1, 0};
        return p;
    endfunction

    function automatic logic [15:0] sig_of(input int st, input logic [3:0] op,
                                           input logic [5:0] fn);
        case (st)
            0:  return 16'h0009;
            1:  return 16'h0820;
            2:  return (fn == 6'd28) ? 16'h2600 : 16'h2400;
            3:  return (op == 4'd4) ? 16'h3400 : 16'h3C00;
            4:  return 16'h1400;
            5:  return 16'h0280;
            6:  return 16'h0200;
            7:  return 16'h0018;
            8:  return 16'h0202;
            9:  return 16'h0014;
            10: return 16'h1000;
            11: return 16'h4440;
            12: return 16'h8020;
            13: return 16'h8320;
            14: return (fn == 6'd26) ? 16'h0720 : 16'h0420;
            default: return 16'h0000;
        endcase
    endfunction

    // Caller guarantees the DUT is sitting in an active IF at a falling edge.
    task automatic run_inst(input logic [3:0] op, input logic [5:0] fn);
        q_t p;
        logic [15:0] exp_sig;
        p = path_of(op, fn);
        opcode = op;
        func   = fn;
        foreach (p[i]) begin
            @(negedge clk);
            exp_sig = sig_of(p[i], op, fn);
            total++;
            if (state !== 4'(p[i]) || signal !== exp_sig) begin
                bad++;
                $display("FAIL path op=%0d fn=%0d step=%0d: state=%0d signal=%h, want state=%0d signal=%h",
                         op, fn, i, state, signal, p[i], exp_sig);
            end
            total++;
            if (signal[3] && signal[2]) begin
                bad++;
                $display("FAIL memrw_excl: signal=%h, want MemRead and MemWrite not both set", signal);
            end
        end
        num_m = num_m + 16'd1;
        total++;
        if (num_inst !== num_m) begin
            bad++;
            $display("FAIL num_inst op=%0d fn=%0d: got %h want %h", op, fn, num_inst, num_m);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        num_m = 16'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #13;
        total++;
        if (state !== 4'd0 || signal !== 16'h0000 || num_inst !== 16'h0000) begin
            bad++;
            $display("FAIL reset_hold: state=%0d signal=%h num=%h, want 0 0000 0000",
                     state, signal, num_inst);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++;
        if (signal !== 16'h0000) begin
            bad++;
            $display("FAIL reset_release_pre_edge: signal=%h want 0000", signal);
        end
        @(negedge clk);
        total++;
        if (state !== 4'd0 || signal !== 16'h0009 || num_inst !== 16'h0000) begin
            bad++;
            $display("FAIL reset_first_edge: state=%0d signal=%h num=%h, want 0 0009 0000",
                     state, signal, num_inst);
        end
        num_m = 16'd0;
    endtask

    task automatic test_adi();
        do_reset();
        run_inst(4'd4, 6'($urandom));
    endtask

    task automatic test_lwd_swd();
        do_reset();
        run_inst(4'd7, 6'($urandom));
        run_inst(4'd8, 6'($urandom));
    endtask

    task automatic test_wwd_jr();
        run_inst(4'd15, 6'd28);
        run_inst(4'd15, 6'd26);
        run_inst(4'd15, 6'd25);
        run_inst(4'd5, 6'd0);
    endtask

    task automatic test_halt();
        run_inst(4'd15, 6'd29);
        for (int i = 0; i < 20; i++) begin
            opcode = 4'($urandom);
            func   = 6'($urandom);
            @(negedge clk);
            total++;
            if (state !== 4'd15 || signal !== 16'h0000 || num_inst !== num_m) begin
                bad++;
                $display("FAIL halt_hold cyc=%0d: state=%0d signal=%h num=%h, want 15 0000 %h",
                         i, state, signal, num_inst, num_m);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || num_inst !== 16'h0000 || signal !== 16'h0000) begin
            bad++;
            $display("FAIL halt_reset: state=%0d num=%h signal=%h, want 0 0000 0000",
                     state, num_inst, signal);
        end
        do_reset();
    endtask

    task automatic test_is_halted();
        do_reset();
        opcode = 4'd4;
        func   = 6'd0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (state !== 4'd3) begin
            bad++;
            $display("FAIL is_halted_pre: state=%0d want 3", state);
        end
        is_halted = 1'b1;
        @(negedge clk);
        is_halted = 1'b0;
        total++;
        if (state !== 4'd15 || signal !== 16'h0000 || num_inst !== 16'd1) begin
            bad++;
            $display("FAIL is_halted_force: state=%0d signal=%h num=%h, want 15 0000 0001",
                     state, signal, num_inst);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [5:0] fn;
        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom);
            fn = 6'($urandom);
            if (op == 4'd15) begin
                case ($urandom_range(0, 3))
                    0: fn = 6'($urandom_range(0, 7));
                    1: fn = 6'd28;
                    2: fn = ($urandom_range(0, 1) == 0) ? 6'd25 : 6'd26;
                    default: if (fn >= 6'd25 && fn <= 6'd29) fn = 6'd63;
                endcase
            end
            run_inst(op, fn);
        end
    endtask

    task automatic test_wrap_abort();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        force dut.num_inst_q = 16'hFFFC;
        reset_n = 1'b1;
        @(posedge clk);
        #1 release dut.num_inst_q;
        @(negedge clk);
        num_m = 16'hFFFC;
        for (int i = 0; i < 4; i++) begin
            run_inst(4'($urandom_range(11, 14)), 6'($urandom));
        end
        total++;
        if (num_inst !== 16'h0000) begin
            bad++;
            $display("FAIL num_wrap: got %h want 0000", num_inst);
        end
        opcode = 4'd7;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (state !== 4'd7 || signal !== 16'h0018) begin
            bad++;
            $display("FAIL abort_pre: state=%0d signal=%h, want 7 0018", state, signal);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || signal !== 16'h0000 || num_inst !== 16'h0000) begin
            bad++;
            $display("FAIL abort_async: state=%0d signal=%h num=%h, want 0 0000 0000",
                     state, signal, num_inst);
        end
        do_reset();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        num_m     = 16'd0;
        reset_n   = 1'b0;
        opcode    = 4'd0;
        func      = 6'd0;
        is_halted = 1'b0;
        test_reset();
        test_adi();
        test_lwd_swd();
        test_wwd_jr();
        test_halt();
        test_is_halted();
        test_random();
        test_wrap_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
